// File: rtl/ftrans_vputy_issue_if.sv
// Command and matrix-register issue bus between the format-transfer controller,
// ftrans_vputy_issue (slave side) and the matrix-register file.
interface ftrans_vputy_issue_if #(
    parameter int MRX_IND_WTH  = 5,
    parameter int MRX_ADDR_WTH = 9
);
    logic [4:0]              ftransctl_vputy__code_i;
    logic [MRX_IND_WTH-1:0]  ftransctl_vputy__mrs0_index_i;
    logic [MRX_ADDR_WTH-1:0] ftransctl_vputy__mrs0_addr_i;
    logic [5:0]              ftransctl_vputy__sv_code_i;
    logic [2:0]              ftransctl_vputy__mtx_sel_h_i;
    logic [MRX_IND_WTH-1:0]  ftransctl_vputy__mrd_index_i;
    logic [MRX_ADDR_WTH-1:0] ftransctl_vputy__mrd_addr_i;
    logic [7:0]              ftransctl_vputy__strobe_h_i;
    logic                    vputy_issue__ready_i;

    logic                    issue_mrx__rd_en_o;
    logic [MRX_IND_WTH-1:0]  issue_mrx__rd_index_o;
    logic [MRX_ADDR_WTH-1:0] issue_mrx__rd_addr_o;
    logic                    issue_mrx__wr_en_o;
    logic [MRX_IND_WTH-1:0]  issue_mrx__wr_index_o;
    logic [MRX_ADDR_WTH-1:0] issue_mrx__wr_addr_o;
    logic [5:0]              issue_mrx__sv_code_o;
    logic [2:0]              issue_mrx__mtx_sel_h_o;
    logic [7:0]              issue_mrx__strobe_h_o;

    modport master (
        output ftransctl_vputy__code_i, ftransctl_vputy__mrs0_index_i,
               ftransctl_vputy__mrs0_addr_i, ftransctl_vputy__sv_code_i,
               ftransctl_vputy__mtx_sel_h_i, ftransctl_vputy__mrd_index_i,
               ftransctl_vputy__mrd_addr_i, ftransctl_vputy__strobe_h_i,
               vputy_issue__ready_i,
        input  issue_mrx__rd_en_o, issue_mrx__rd_index_o, issue_mrx__rd_addr_o,
               issue_mrx__wr_en_o, issue_mrx__wr_index_o, issue_mrx__wr_addr_o,
               issue_mrx__sv_code_o, issue_mrx__mtx_sel_h_o, issue_mrx__strobe_h_o
    );

    modport slave (
        input  ftransctl_vputy__code_i, ftransctl_vputy__mrs0_index_i,
               ftransctl_vputy__mrs0_addr_i, ftransctl_vputy__sv_code_i,
               ftransctl_vputy__mtx_sel_h_i, ftransctl_vputy__mrd_index_i,
               ftransctl_vputy__mrd_addr_i, ftransctl_vputy__strobe_h_i,
               vputy_issue__ready_i,
        output issue_mrx__rd_en_o, issue_mrx__rd_index_o, issue_mrx__rd_addr_o,
               issue_mrx__wr_en_o, issue_mrx__wr_index_o, issue_mrx__wr_addr_o,
               issue_mrx__sv_code_o, issue_mrx__mtx_sel_h_o, issue_mrx__strobe_h_o
    );
endinterface

// File: rtl/ftrans_vputy_issue.sv
// Command FIFO plus matrix-register read/write issue between ftransctl and vputy.
// Define FTRANS_ISSUE_PERF_EN to add the issue/stall performance counters.
module ftrans_vputy_issue #(
    parameter int MRX_IND_WTH  = 5,
    parameter int MRX_ADDR_WTH = 9,
    parameter int FIFO_DEPTH   = 16,
    parameter int RD_LAT       = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    ftrans_vputy_issue_if.slave           bus,
    input  logic                          regmap_issue__clr_ovf_i,
    output logic                          regmap_issue__ovf_o,
    output logic                          regmap_issue__done_o,
    output logic                          regmap_issue__idle_o,
    output logic [$clog2(FIFO_DEPTH):0]   regmap_issue__level_o
`ifdef FTRANS_ISSUE_PERF_EN
    ,
    output logic [15:0]                   regmap_issue__issue_cnt_o,
    output logic [15:0]                   regmap_issue__stall_cnt_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [4:0]              code;
        logic [MRX_IND_WTH-1:0]  src_idx;
        logic [MRX_ADDR_WTH-1:0] src_addr;
        logic [5:0]              sv_code;
        logic [2:0]              mtx_sel;
        logic [MRX_IND_WTH-1:0]  dst_idx;
        logic [MRX_ADDR_WTH-1:0] dst_addr;
        logic [7:0]              strobe;
    } cmd_t;

    typedef struct packed {
        logic                    valid;
        logic [MRX_IND_WTH-1:0]  idx;
        logic [MRX_ADDR_WTH-1:0] addr;
        logic [5:0]              sv_code;
        logic [2:0]              mtx_sel;
        logic [7:0]              strobe;
    } wr_t;

    cmd_t                    mem_q [FIFO_DEPTH];
    logic [LW-1:0]           wr_ptr_q, rd_ptr_q, level;
    logic [1:0]              state_q, state_d;
    logic                    ovf_q, ovf_d;
    logic                    rd_en_q;
    logic [MRX_IND_WTH-1:0]  rd_idx_q;
    logic [MRX_ADDR_WTH-1:0] rd_addr_q;
    wr_t                     dl_q [0:RD_LAT];

    cmd_t push_cmd, head;
    logic push_req, fifo_empty, fifo_full, pop, push_acc, drop, dl_busy;
    logic unused_code;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign push_req   = bus.ftransctl_vputy__code_i[0];
    assign pop        = !fifo_empty && bus.vputy_issue__ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc   = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push_acc;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign push_cmd = '{
        code:     bus.ftransctl_vputy__code_i,
        src_idx:  bus.ftransctl_vputy__mrs0_index_i,
        src_addr: bus.ftransctl_vputy__mrs0_addr_i,
        sv_code:  bus.ftransctl_vputy__sv_code_i,
        mtx_sel:  bus.ftransctl_vputy__mtx_sel_h_i,
        dst_idx:  bus.ftransctl_vputy__mrd_index_i,
        dst_addr: bus.ftransctl_vputy__mrd_addr_i,
        strobe:   bus.ftransctl_vputy__strobe_h_i
    };

    assign unused_code = ^{head.code, bus.ftransctl_vputy__code_i[4:1]};

    // NOTE: storage array has no reset; only pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_IDLE;
            ovf_q    <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + LW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + LW'(1);
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        dl_busy = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            dl_busy = dl_busy | dl_q[i].valid;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a comb output unassigned (no latch).
        state_d = state_q;
        ovf_d   = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (regmap_issue__clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        case (state_q)
            ST_IDLE:  if (push_acc) state_d = ST_RUN;
            ST_RUN:   if (!push_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (push_acc) begin
                    state_d = ST_RUN;
                end else if (fifo_empty && !dl_busy && !push_req) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read port is one register stage after the pop; the write side follows
    // RD_LAT further stages behind it and never stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_en_q   <= 1'b0;
            rd_idx_q  <= '0;
            rd_addr_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            rd_en_q        <= pop;
            dl_q[0].valid  <= pop;
            if (pop) begin
                rd_idx_q        <= head.src_idx;
                rd_addr_q       <= head.src_addr;
                dl_q[0].idx     <= head.dst_idx;
                dl_q[0].addr    <= head.dst_addr;
                dl_q[0].sv_code <= head.sv_code;
                dl_q[0].mtx_sel <= head.mtx_sel;
                dl_q[0].strobe  <= head.strobe;
            end
            for (int i = 1; i <= RD_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign bus.issue_mrx__rd_en_o     = rd_en_q;
    assign bus.issue_mrx__rd_index_o  = rd_idx_q;
    assign bus.issue_mrx__rd_addr_o   = rd_addr_q;
    assign bus.issue_mrx__wr_en_o     = dl_q[RD_LAT].valid;
    assign bus.issue_mrx__wr_index_o  = dl_q[RD_LAT].idx;
    assign bus.issue_mrx__wr_addr_o   = dl_q[RD_LAT].addr;
    assign bus.issue_mrx__sv_code_o   = dl_q[RD_LAT].sv_code;
    assign bus.issue_mrx__mtx_sel_h_o = dl_q[RD_LAT].mtx_sel;
    assign bus.issue_mrx__strobe_h_o  = dl_q[RD_LAT].strobe;

    assign regmap_issue__ovf_o   = ovf_q;
    assign regmap_issue__done_o  = (state_q == ST_DONE);
    assign regmap_issue__idle_o  = (state_q == ST_IDLE);
    assign regmap_issue__level_o = level;

`ifdef FTRANS_ISSUE_PERF_EN
    logic [15:0] issue_cnt_q, stall_cnt_q;
    logic        run_start;

    assign run_start = (state_q == ST_IDLE) && push_acc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (run_start) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (rd_en_q && (issue_cnt_q != 16'hFFFF)) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (!fifo_empty && !bus.vputy_issue__ready_i && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign regmap_issue__issue_cnt_o = issue_cnt_q;
    assign regmap_issue__stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ftrans_vputy_issue.sv
// Self-checking bench for ftrans_vputy_issue: a queue-based reference model is
// compared every cycle, with directed literal checks pinning the model.
`timescale 1ns/1ps
module tb_ftrans_vputy_issue;

    localparam int IW     = 5;
    localparam int AWD    = 9;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;
    localparam int LVW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0] src_idx;
        logic [8:0] src_addr;
        logic [4:0] dst_idx;
        logic [8:0] dst_addr;
        logic [5:0] sv;
        logic [2:0] mtx;
        logic [7:0] strobe;
    } cmd_t;

    typedef struct packed {
        logic [31:0] due;
        cmd_t        c;
    } wr_ev_t;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_e;

    logic           clk, rst_n, clr_ovf;
    logic           ovf, done, idle;
    logic [LVW-1:0] level;
`ifdef FTRANS_ISSUE_PERF_EN
    logic [15:0]    issue_cnt, stall_cnt;
`endif

    ftrans_vputy_issue_if #(.MRX_IND_WTH(IW), .MRX_ADDR_WTH(AWD)) bus ();

    ftrans_vputy_issue #(
        .MRX_IND_WTH(IW), .MRX_ADDR_WTH(AWD), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk_i                   (clk),
        .rst_n_i                 (rst_n),
        .bus                     (bus),
        .regmap_issue__clr_ovf_i (clr_ovf),
        .regmap_issue__ovf_o     (ovf),
        .regmap_issue__done_o    (done),
        .regmap_issue__idle_o    (idle),
        .regmap_issue__level_o   (level)
`ifdef FTRANS_ISSUE_PERF_EN
        ,
        .regmap_issue__issue_cnt_o (issue_cnt),
        .regmap_issue__stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    cmd_t        mq[$];
    wr_ev_t      wq[$];
    logic        m_rd_en;
    logic [4:0]  m_rd_idx;
    logic [8:0]  m_rd_addr;
    logic        m_ovf;
    mst_e        m_st;
    logic [31:0] cyc = 0;
    int          m_issue, m_stall;

    function automatic cmd_t cur_cmd();
        cmd_t c;
        c.src_idx  = bus.ftransctl_vputy__mrs0_index_i;
        c.src_addr = bus.ftransctl_vputy__mrs0_addr_i;
        c.dst_idx  = bus.ftransctl_vputy__mrd_index_i;
        c.dst_addr = bus.ftransctl_vputy__mrd_addr_i;
        c.sv       = bus.ftransctl_vputy__sv_code_i;
        c.mtx      = bus.ftransctl_vputy__mtx_sel_h_i;
        c.strobe   = bus.ftransctl_vputy__strobe_h_i;
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        wq.delete();
        m_rd_en   = 1'b0;
        m_rd_idx  = '0;
        m_rd_addr = '0;
        m_ovf     = 1'b0;
        m_st      = M_IDLE;
        m_issue   = 0;
        m_stall   = 0;
    endtask

    task automatic model_step();
        int unsigned sz;
        bit pop, push, acc, busy, rdy, start;
        cmd_t c;
        sz    = mq.size();
        rdy   = bus.vputy_issue__ready_i;
        pop   = (sz != 0) && rdy;
        push  = bus.ftransctl_vputy__code_i[0];
        acc   = push && ((sz < DEPTH) || pop);
        busy  = (wq.size() != 0);
        start = (m_st == M_IDLE) && acc;

        if (start) begin
            m_issue = 0;
            m_stall = 0;
        end else begin
            if (m_rd_en && m_issue < 65535) m_issue++;
            if (sz != 0 && !rdy && m_stall < 65535) m_stall++;
        end

        case (m_st)
            M_IDLE:  if (acc) m_st = M_RUN;
            M_RUN:   if (!push) m_st = M_DRAIN;
            M_DRAIN: if (acc) m_st = M_RUN;
                     else if (sz == 0 && !busy && !push) m_st = M_DONE;
            default: m_st = M_IDLE;
        endcase

        m_rd_en = pop;
        if (pop) begin
            c = mq.pop_front();
            m_rd_idx  = c.src_idx;
            m_rd_addr = c.src_addr;
            wq.push_back('{due: cyc + 1 + RD_LAT, c: c});
        end
        if (acc) mq.push_back(cur_cmd());
        if (push && !acc)  m_ovf = 1'b1;
        else if (clr_ovf)  m_ovf = 1'b0;

        cyc++;
        while (wq.size() != 0 && wq[0].due < cyc) void'(wq.pop_front());
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int rd_cnt = 0, wr_cnt = 0, max_lvl = 0;

    initial begin : compare
        bit exp_wr;
        forever begin
            @(negedge clk);
            exp_wr = (wq.size() != 0) && (wq[0].due == cyc);
            check("rd_en", bus.issue_mrx__rd_en_o, m_rd_en);
            check("rd_index", bus.issue_mrx__rd_index_o, m_rd_idx);
            check("rd_addr", bus.issue_mrx__rd_addr_o, m_rd_addr);
            check("wr_en", bus.issue_mrx__wr_en_o, exp_wr);
            if (exp_wr) begin
                check("wr_fields",
                      {bus.issue_mrx__wr_index_o, bus.issue_mrx__wr_addr_o, bus.issue_mrx__sv_code_o,
                       bus.issue_mrx__mtx_sel_h_o, bus.issue_mrx__strobe_h_o},
                      {wq[0].c.dst_idx, wq[0].c.dst_addr, wq[0].c.sv, wq[0].c.mtx, wq[0].c.strobe});
            end
            check("level", level, mq.size());
            check("ovf", ovf, m_ovf);
            check("done", done, m_st == M_DONE);
            check("idle", idle, m_st == M_IDLE);
`ifdef FTRANS_ISSUE_PERF_EN
            check("issue_cnt", issue_cnt, m_issue);
            check("stall_cnt", stall_cnt, m_stall);
`endif
            if (bus.issue_mrx__rd_en_o) rd_cnt++;
            if (bus.issue_mrx__wr_en_o) wr_cnt++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit push, input bit rdy, input bit clr);
        bus.ftransctl_vputy__code_i       = {4'($urandom), push};
        bus.ftransctl_vputy__mrs0_index_i = 5'($urandom);
        bus.ftransctl_vputy__mrs0_addr_i  = 9'($urandom);
        bus.ftransctl_vputy__sv_code_i    = 6'($urandom);
        bus.ftransctl_vputy__mtx_sel_h_i  = 3'($urandom);
        bus.ftransctl_vputy__mrd_index_i  = 5'($urandom);
        bus.ftransctl_vputy__mrd_addr_i   = 9'($urandom);
        bus.ftransctl_vputy__strobe_h_i   = 8'(1 << $urandom_range(0, 7));
        bus.vputy_issue__ready_i          = rdy;
        clr_ovf                           = clr;
    endtask

    task automatic step(input bit push, input bit rdy, input bit clr);
        @(negedge clk);
        drive(push, rdy, clr);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (done) seen = 1'b1;
        end
        check(name, seen, 1'b1);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_rd_en", bus.issue_mrx__rd_en_o, 1'b0);
        check("rst_wr_en", bus.issue_mrx__wr_en_o, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_level", level, 0);

        // Single command: rd two cycles after push, wr RD_LAT after that
        step(1'b1, 1'b1, 1'b0);
        bus.ftransctl_vputy__mrs0_addr_i = 9'h010;
        bus.ftransctl_vputy__mrd_addr_i  = 9'h020;
        bus.ftransctl_vputy__strobe_h_i  = 8'h10;
        step(1'b0, 1'b1, 1'b0);
        check("single_level", level, 1);
        check("single_rd_early", bus.issue_mrx__rd_en_o, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("single_rd_en", bus.issue_mrx__rd_en_o, 1'b1);
        check("single_rd_addr", bus.issue_mrx__rd_addr_o, 9'h010);
        check("single_wr_early", bus.issue_mrx__wr_en_o, 1'b0);
        repeat (RD_LAT) step(1'b0, 1'b1, 1'b0);
        check("single_wr_en", bus.issue_mrx__wr_en_o, 1'b1);
        check("single_wr_addr", bus.issue_mrx__wr_addr_o, 9'h020);
        check("single_wr_strobe", bus.issue_mrx__strobe_h_o, 8'h10);
        wait_done("single_done", 20);
        check("single_idle", idle, 1'b1);

        // 64 back-to-back commands with ready high
        rd_cnt = 0; wr_cnt = 0; max_lvl = 0;
        repeat (64) step(1'b1, 1'b1, 1'b0);
        wait_done("stream_done", 40);
        check("stream_rd_cnt", rd_cnt, 64);
        check("stream_wr_cnt", wr_cnt, 64);
        check("stream_level_le2", max_lvl <= 2, 1'b1);
        check("stream_ovf", ovf, 1'b0);

        // Overflow: 20 pushes into a stalled 16-deep FIFO
        repeat (20) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("ovf_level_full", level, 16);
        check("ovf_set", ovf, 1'b1);
        rd_cnt = 0;
        wait_done("ovf_done", 60);
        check("ovf_rd_cnt", rd_cnt, 16);

        // Full FIFO with push+pop, then drop coinciding with clear
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("clr_ovf", ovf, 1'b0);
        repeat (16) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("full_pushpop_level", level, 16);
        check("full_pushpop_ovf", ovf, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("drop_beats_clr_ovf", ovf, 1'b1);
        check("drop_level", level, 16);
        wait_done("full_done", 60);

        // Random traffic against the model
        repeat (600) step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 5);
        repeat (2) step(1'b1, 1'b1, 1'b0);
        wait_done("random_done", 100);

        // Reset mid-stream: 8 queued, 2 in flight
        repeat (10) step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("prerst_level", level, 8);
        check("prerst_rd_en", bus.issue_mrx__rd_en_o, 1'b1);
        #2 rst_n = 1'b0;
        bus.vputy_issue__ready_i = 1'b0;
        #1;
        check("midrst_rd_en", bus.issue_mrx__rd_en_o, 1'b0);
        check("midrst_rd_addr", bus.issue_mrx__rd_addr_o, 9'h000);
        check("midrst_wr_en", bus.issue_mrx__wr_en_o, 1'b0);
        check("midrst_wr_addr", bus.issue_mrx__wr_addr_o, 9'h000);
        check("midrst_level", level, 0);
        check("midrst_idle", idle, 1'b1);
        check("midrst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rd_cnt = 0; wr_cnt = 0;
        repeat (12) step(1'b0, 1'b1, 1'b0);
        check("postrst_wr_cnt", wr_cnt, 0);
        check("postrst_rd_cnt", rd_cnt, 0);
        check("postrst_idle", idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
